// File: rtl/fp_pkg.sv
// fp_pkg: types and helpers shared by the pipelined floating-point units.
// Formats are generic in exponent/fraction width; bfloat16 is the default.
package fp_pkg;

   typedef enum logic [1:0] {
      FP_ZERO = 2'd0,
      FP_NORM = 2'd1,
      FP_INF  = 2'd2,
      FP_NAN  = 2'd3
   } fp_class_e;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Quiet NaN with only the top fraction bit set; caller truncates to W.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] w_q;
      w_q = ((64'd1 << exp_w) - 64'd1) << man_w;
      w_q = w_q | (64'd1 << (man_w - 1));
      return w_q;
   endfunction

   function automatic fp_class_e fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic frac_zero);
      fp_class_e w_c;
      if (exp_zero)
         w_c = FP_ZERO;
      else if (exp_ones)
         w_c = frac_zero ? FP_INF : FP_NAN;
      else
         w_c = FP_NORM;
      return w_c;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: round-to-nearest-even, range check and packing.
// Purely combinational so it can sit in the last stage of mul or add.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
) (
   input  logic                      i_sign,
   input  logic signed [EXP_W+1:0]   i_exp,
   input  logic [MAN_W:0]            i_mant,
   input  logic                      i_guard,
   input  logic                      i_sticky,
   input  fp_class_e                 i_cls,
   output logic [EXP_W+MAN_W:0]      o_word,
   output logic [3:0]                o_flags
);

   localparam int W = 1 + EXP_W + MAN_W;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
   localparam logic signed [EXP_W+1:0] EXP_MAX = {2'b00, EXP_ONES};
   localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

   logic                    w_round_up;
   logic [MAN_W+1:0]        w_sum;
   logic                    w_carry;
   logic [MAN_W-1:0]        w_frac;
   logic signed [EXP_W+1:0] w_exp;
   logic                    w_inexact;

   assign w_round_up = i_guard & (i_sticky | i_mant[0]);
   assign w_sum      = {1'b0, i_mant} + {{(MAN_W+1){1'b0}}, w_round_up};
   assign w_carry    = w_sum[MAN_W+1];
   // A carry leaves 10..0, so the shifted fraction is all zeros.
   assign w_frac     = w_carry ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
   assign w_exp      = i_exp + $signed({{(EXP_W+1){1'b0}}, w_carry});
   assign w_inexact  = i_guard | i_sticky;

   always_comb begin
      o_word  = '0;
      o_flags = '0;
      unique case (i_cls)
         FP_NAN: begin
            o_word                = QNAN;
            o_flags[FLAG_INVALID] = 1'b1;
         end
         FP_INF: begin
            o_word = {i_sign, EXP_ONES, {MAN_W{1'b0}}};
         end
         FP_ZERO: begin
            o_word = {i_sign, {(EXP_W+MAN_W){1'b0}}};
         end
         default: begin
            if (w_exp >= EXP_MAX) begin
               o_word                 = {i_sign, EXP_ONES, {MAN_W{1'b0}}};
               o_flags[FLAG_OVERFLOW] = 1'b1;
               o_flags[FLAG_INEXACT]  = 1'b1;
            end else if (w_exp <= EXP_ZERO) begin
               o_word                  = {i_sign, {(EXP_W+MAN_W){1'b0}}};
               o_flags[FLAG_UNDERFLOW] = 1'b1;
               o_flags[FLAG_INEXACT]   = 1'b1;
            end else begin
               o_word                = {i_sign, w_exp[EXP_W-1:0], w_frac};
               o_flags[FLAG_INEXACT] = w_inexact;
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage floating-point multiplier, valid/ready stream.
// One global enable stalls every stage together; only valid bits reset.
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [EXP_W+MAN_W:0]  in_a,
   input  logic [EXP_W+MAN_W:0]  in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXP_W+MAN_W:0]  out_result,
   output logic [3:0]            out_flags
);

   localparam int W = 1 + EXP_W + MAN_W;
   localparam int P = 2 * MAN_W + 2;
   localparam int BIAS_I = fp_bias(EXP_W);
   localparam logic signed [EXP_W+1:0] BIAS = BIAS_I[EXP_W+1:0];

   logic w_adv;
   logic r1_valid, r2_valid, r3_valid;

   logic                    w_sa, w_sb;
   logic [EXP_W-1:0]        w_ea, w_eb;
   logic [MAN_W-1:0]        w_fa, w_fb;
   fp_class_e               w_ca, w_cb, w_cls1;
   logic signed [EXP_W+1:0] w_esum;

   logic                    r1_sign;
   fp_class_e               r1_cls;
   logic signed [EXP_W+1:0] r1_exp;
   logic [MAN_W:0]          r1_ma, r1_mb;
   logic [P-1:0]            w_prod;

   logic                    r2_sign;
   fp_class_e               r2_cls;
   logic signed [EXP_W+1:0] r2_exp;
   logic [P-1:0]            r2_prod;

   logic                    w_shift;
   logic signed [EXP_W+1:0] w_exp3;
   logic [MAN_W:0]          w_mant3;
   logic                    w_guard, w_sticky;
   logic [W-1:0]            w_word;
   logic [3:0]              w_flags;
   logic [W-1:0]            r3_word;
   logic [3:0]              r3_flags;

   assign w_adv    = !r3_valid || out_ready;
   assign in_ready = w_adv;

   assign {w_sa, w_ea, w_fa} = in_a;
   assign {w_sb, w_eb, w_fb} = in_b;
   assign w_ca = fp_classify(w_ea == '0, &w_ea, w_fa == '0);
   assign w_cb = fp_classify(w_eb == '0, &w_eb, w_fb == '0);
   assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

   always_comb begin
      w_cls1 = FP_NORM;
      if (w_ca == FP_NAN || w_cb == FP_NAN ||
          (w_ca == FP_INF && w_cb == FP_ZERO) ||
          (w_ca == FP_ZERO && w_cb == FP_INF))
         w_cls1 = FP_NAN;
      else if (w_ca == FP_INF || w_cb == FP_INF)
         w_cls1 = FP_INF;
      else if (w_ca == FP_ZERO || w_cb == FP_ZERO)
         w_cls1 = FP_ZERO;
   end

   assign w_prod = {{(MAN_W+1){1'b0}}, r1_ma} * {{(MAN_W+1){1'b0}}, r1_mb};

   // Product lies in [1,4); the MSB picks which window holds the mantissa.
   assign w_shift = r2_prod[P-1];
   assign w_exp3  = r2_exp + $signed({{(EXP_W+1){1'b0}}, w_shift});

   always_comb begin
      if (w_shift) begin
         w_mant3  = r2_prod[P-1 -: MAN_W+1];
         w_guard  = r2_prod[MAN_W];
         w_sticky = |r2_prod[MAN_W-1:0];
      end else begin
         w_mant3  = r2_prod[P-2 -: MAN_W+1];
         w_guard  = r2_prod[MAN_W-1];
         w_sticky = |r2_prod[MAN_W-2:0];
      end
   end

   fp_round_pack #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round_pack (
      .i_sign   (r2_sign),
      .i_exp    (w_exp3),
      .i_mant   (w_mant3),
      .i_guard  (w_guard),
      .i_sticky (w_sticky),
      .i_cls    (r2_cls),
      .o_word   (w_word),
      .o_flags  (w_flags)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r2_valid <= 1'b0;
         r3_valid <= 1'b0;
      end else if (w_adv) begin
         r1_valid <= in_valid;
         r2_valid <= r1_valid;
         r3_valid <= r2_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r1_sign  <= w_sa ^ w_sb;
         r1_cls   <= w_cls1;
         r1_exp   <= w_esum;
         r1_ma    <= {1'b1, w_fa};
         r1_mb    <= {1'b1, w_fb};
         r2_sign  <= r1_sign;
         r2_cls   <= r1_cls;
         r2_exp   <= r1_exp;
         r2_prod  <= w_prod;
         r3_word  <= w_word;
         r3_flags <= w_flags;
      end
   end

   // Data registers are not reset, so mask them while nothing is valid.
   assign out_valid  = r3_valid;
   assign out_result = r3_valid ? r3_word : '0;
   assign out_flags  = r3_valid ? r3_flags : '0;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and streaming checks of the pipelined multiplier.
// A bfloat16 and a binary16 instance share the same input stream.
module tb_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] in_a, in_b;

   logic        bf_in_ready, bf_out_valid;
   logic [15:0] bf_out_result;
   logic [3:0]  bf_out_flags;
   logic        hf_in_ready, hf_out_valid;
   logic [15:0] hf_out_result;
   logic [3:0]  hf_out_flags;

   int errs   = 0;
   int checks = 0;

   typedef struct packed {
      logic        hf;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic [3:0]  f;
   } vec_t;

   always #5 clk = ~clk;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(7)) u_bf (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (bf_in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (bf_out_valid),
      .out_ready  (out_ready),
      .out_result (bf_out_result),
      .out_flags  (bf_out_flags)
   );

   fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_hf (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (hf_in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (hf_out_valid),
      .out_ready  (out_ready),
      .out_result (hf_out_result),
      .out_flags  (hf_out_flags)
   );

   // Reference: exact integer product, then remainder-vs-half rounding.
   function automatic logic [19:0] ref_mul(input int ew, input int mw,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
      int bias, emax, ea, eb, e, sh;
      longint one, fa, fb, p, q, rem, half;
      logic [15:0] sgn, infw;
      bit za, zb, ia, ib, na, nb, inx;
      bias = (1 << (ew - 1)) - 1;
      emax = (1 << ew) - 1;
      sgn  = (a[15] ^ b[15]) ? 16'h8000 : 16'h0000;
      infw = sgn | 16'(emax << mw);
      one  = longint'(1) << mw;
      ea   = (int'(a) >> mw) & emax;
      eb   = (int'(b) >> mw) & emax;
      fa   = longint'(a) & (one - 1);
      fb   = longint'(b) & (one - 1);
      za = (ea == 0); zb = (eb == 0);
      ia = (ea == emax) && (fa == 0);
      ib = (eb == emax) && (fb == 0);
      na = (ea == emax) && (fa != 0);
      nb = (eb == emax) && (fb != 0);
      if (na || nb || (ia && zb) || (za && ib))
         return {4'b1000, 16'((emax << mw) | (1 << (mw - 1)))};
      if (ia || ib) return {4'b0000, infw};
      if (za || zb) return {4'b0000, sgn};
      p  = (one | fa) * (one | fb);
      e  = ea + eb - bias;
      sh = mw;
      if (p >= (longint'(1) << (2 * mw + 1))) begin
         e++;
         sh = mw + 1;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == (one << 1)) begin
         q = q >> 1;
         e++;
      end
      if (e >= emax) return {4'b0101, infw};
      if (e <= 0) return {4'b0011, sgn};
      return {3'b000, inx, sgn | 16'(e << mw) | 16'(q - one)};
   endfunction

   // Push one operand pair into an empty pipe and wait for its result.
   task automatic xfer(input logic hf, input logic [15:0] a,
                       input logic [15:0] b, output int lat,
                       output logic [15:0] res, output logic [3:0] fl);
      @(negedge clk);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!(hf ? hf_out_valid : bf_out_valid) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      res = hf ? hf_out_result : bf_out_result;
      fl  = hf ? hf_out_flags : bf_out_flags;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in_a = '0;
      in_b = '0;
      #2;
      checks += 4;
      if (bf_out_valid !== 1'b0 || hf_out_valid !== 1'b0) begin
         errs++;
         $display("FAIL reset out_valid: got %b/%b want 0/0", bf_out_valid, hf_out_valid);
      end
      if (bf_out_result !== 16'h0 || hf_out_result !== 16'h0) begin
         errs++;
         $display("FAIL reset out_result: got %h/%h want 0000", bf_out_result, hf_out_result);
      end
      if (bf_out_flags !== 4'h0 || hf_out_flags !== 4'h0) begin
         errs++;
         $display("FAIL reset out_flags: got %b/%b want 0000", bf_out_flags, hf_out_flags);
      end
      if (bf_in_ready !== 1'b1 || hf_in_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset in_ready: got %b/%b want 1", bf_in_ready, hf_in_ready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      vec_t v[2];
      int lat;
      logic [15:0] res;
      logic [3:0] fl;
      v[0] = '{1'b0, 16'h3FC0, 16'h4000, 16'h4040, 4'b0000};
      v[1] = '{1'b1, 16'h3E00, 16'h4000, 16'h4200, 4'b0000};
      foreach (v[i]) begin
         xfer(v[i].hf, v[i].a, v[i].b, lat, res, fl);
         checks += 3;
         if (lat !== 3) begin
            errs++;
            $display("FAIL basic[%0d] latency: got %0d want 3", i, lat);
         end
         if (res !== v[i].r) begin
            errs++;
            $display("FAIL basic[%0d] result: got %h want %h", i, res, v[i].r);
         end
         if (fl !== v[i].f) begin
            errs++;
            $display("FAIL basic[%0d] flags: got %b want %b", i, fl, v[i].f);
         end
      end
   endtask

   task automatic test_round();
      vec_t v[4];
      int lat;
      logic [15:0] res;
      logic [3:0] fl;
      v[0] = '{1'b0, 16'h3F81, 16'h3FC0, 16'h3FC2, 4'b0001};
      v[1] = '{1'b0, 16'h3F81, 16'h3F81, 16'h3F82, 4'b0001};
      v[2] = '{1'b1, 16'h3C01, 16'h3E00, 16'h3E02, 4'b0001};
      v[3] = '{1'b1, 16'h3C01, 16'h3C01, 16'h3C02, 4'b0001};
      foreach (v[i]) begin
         xfer(v[i].hf, v[i].a, v[i].b, lat, res, fl);
         checks += 2;
         if (res !== v[i].r) begin
            errs++;
            $display("FAIL round[%0d] result: got %h want %h", i, res, v[i].r);
         end
         if (fl !== v[i].f) begin
            errs++;
            $display("FAIL round[%0d] flags: got %b want %b", i, fl, v[i].f);
         end
      end
   endtask

   task automatic test_special();
      vec_t v[6];
      int lat;
      logic [15:0] res;
      logic [3:0] fl;
      v[0] = '{1'b0, 16'h7F80, 16'h8000, 16'h7FC0, 4'b1000};
      v[1] = '{1'b0, 16'h7FC1, 16'h3F80, 16'h7FC0, 4'b1000};
      v[2] = '{1'b0, 16'hFF80, 16'h4000, 16'hFF80, 4'b0000};
      v[3] = '{1'b1, 16'h7C00, 16'h8000, 16'h7E00, 4'b1000};
      v[4] = '{1'b1, 16'h7C01, 16'h3C00, 16'h7E00, 4'b1000};
      v[5] = '{1'b1, 16'hFC00, 16'h4000, 16'hFC00, 4'b0000};
      foreach (v[i]) begin
         xfer(v[i].hf, v[i].a, v[i].b, lat, res, fl);
         checks += 2;
         if (res !== v[i].r) begin
            errs++;
            $display("FAIL special[%0d] result: got %h want %h", i, res, v[i].r);
         end
         if (fl !== v[i].f) begin
            errs++;
            $display("FAIL special[%0d] flags: got %b want %b", i, fl, v[i].f);
         end
      end
   endtask

   task automatic test_range();
      vec_t v[6];
      int lat;
      logic [15:0] res;
      logic [3:0] fl;
      v[0] = '{1'b0, 16'h7F00, 16'h7F00, 16'h7F80, 4'b0101};
      v[1] = '{1'b0, 16'h0080, 16'h3F00, 16'h0000, 4'b0011};
      v[2] = '{1'b0, 16'h8080, 16'h3F00, 16'h8000, 4'b0011};
      v[3] = '{1'b1, 16'h7800, 16'h7800, 16'h7C00, 4'b0101};
      v[4] = '{1'b1, 16'h0400, 16'h3800, 16'h0000, 4'b0011};
      v[5] = '{1'b1, 16'h8400, 16'h3800, 16'h8000, 4'b0011};
      foreach (v[i]) begin
         xfer(v[i].hf, v[i].a, v[i].b, lat, res, fl);
         checks += 2;
         if (res !== v[i].r) begin
            errs++;
            $display("FAIL range[%0d] result: got %h want %h", i, res, v[i].r);
         end
         if (fl !== v[i].f) begin
            errs++;
            $display("FAIL range[%0d] flags: got %b want %b", i, fl, v[i].f);
         end
      end
   endtask

   task automatic test_stream();
      logic [15:0] va[10], vb[10];
      logic [19:0] eb[10], eh[10];
      logic [15:0] hold_b, hold_h;
      logic [3:0]  holdf_b, holdf_h;
      logic        hold;
      int sent, got, cyc, extra;
      for (int i = 0; i < 10; i++) begin
         va[i] = {1'($urandom), 1'(i), ~1'(i), 13'($urandom)};
         vb[i] = {1'($urandom), ~1'(i), 1'(i), 13'($urandom)};
         eb[i] = ref_mul(8, 7, va[i], vb[i]);
         eh[i] = ref_mul(5, 10, va[i], vb[i]);
      end
      sent = 0;
      got = 0;
      cyc = 0;
      hold = 1'b0;
      while (got < 10 && cyc < 400) begin
         @(negedge clk);
         out_ready = 1'($urandom_range(0, 1));
         in_valid = (sent < 10);
         if (sent < 10) begin
            in_a = va[sent];
            in_b = vb[sent];
         end
         #1;
         if (hold) begin
            checks++;
            if (bf_out_valid !== 1'b1 || hf_out_valid !== 1'b1 ||
                bf_out_result !== hold_b || hf_out_result !== hold_h ||
                bf_out_flags !== holdf_b || hf_out_flags !== holdf_h) begin
               errs++;
               $display("FAIL stream hold: got %h/%h want %h/%h", bf_out_result, hf_out_result, hold_b, hold_h);
            end
         end
         if (in_valid && bf_in_ready) sent++;
         if (bf_out_valid && out_ready) begin
            checks += 4;
            if (bf_out_result !== eb[got][15:0]) begin
               errs++;
               $display("FAIL stream bf16[%0d] result: got %h want %h", got, bf_out_result, eb[got][15:0]);
            end
            if (bf_out_flags !== eb[got][19:16]) begin
               errs++;
               $display("FAIL stream bf16[%0d] flags: got %b want %b", got, bf_out_flags, eb[got][19:16]);
            end
            if (hf_out_result !== eh[got][15:0]) begin
               errs++;
               $display("FAIL stream fp16[%0d] result: got %h want %h", got, hf_out_result, eh[got][15:0]);
            end
            if (hf_out_flags !== eh[got][19:16]) begin
               errs++;
               $display("FAIL stream fp16[%0d] flags: got %b want %b", got, hf_out_flags, eh[got][19:16]);
            end
            got++;
         end
         hold    = bf_out_valid && !out_ready;
         hold_b  = bf_out_result;
         hold_h  = hf_out_result;
         holdf_b = bf_out_flags;
         holdf_h = hf_out_flags;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 10) begin
         errs++;
         $display("FAIL stream count: got %0d want 10", got);
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (bf_out_valid || hf_out_valid) extra++;
      end
      checks++;
      if (extra != 0) begin
         errs++;
         $display("FAIL stream duplicate: got %0d extra want 0", extra);
      end
   endtask

   task automatic test_reset_flight();
      logic [15:0] ra[3];
      int lat, seen;
      logic [15:0] res;
      logic [3:0] fl;
      ra[0] = 16'h3FC0;
      ra[1] = 16'h4000;
      ra[2] = 16'h3F81;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_a = ra[i];
         in_b = 16'h4000;
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (bf_out_valid !== 1'b1 || bf_in_ready !== 1'b0) begin
         errs++;
         $display("FAIL flight stall: got valid=%b ready=%b want 1/0", bf_out_valid, bf_in_ready);
      end
      #2 rst = 1'b1;
      #1;
      checks += 2;
      if (bf_out_valid !== 1'b0 || hf_out_valid !== 1'b0) begin
         errs++;
         $display("FAIL flight reset valid: got %b/%b want 0/0", bf_out_valid, hf_out_valid);
      end
      if (bf_in_ready !== 1'b1 || bf_out_result !== 16'h0) begin
         errs++;
         $display("FAIL flight reset outputs: got ready=%b res=%h want 1/0000", bf_in_ready, bf_out_result);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bf_out_valid || hf_out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errs++;
         $display("FAIL flight leak: got %0d outputs want 0", seen);
      end
      xfer(1'b0, 16'h3F81, 16'h3F81, lat, res, fl);
      checks += 2;
      if (lat !== 3) begin
         errs++;
         $display("FAIL flight latency: got %0d want 3", lat);
      end
      if (res !== 16'h3F82 || fl !== 4'b0001) begin
         errs++;
         $display("FAIL flight bf16 result: got %h/%b want 3F82/0001", res, fl);
      end
      xfer(1'b1, 16'h3C01, 16'h3C01, lat, res, fl);
      checks++;
      if (res !== 16'h3C02 || fl !== 4'b0001) begin
         errs++;
         $display("FAIL flight fp16 result: got %h/%b want 3C02/0001", res, fl);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round();
      test_special();
      test_range();
      test_stream();
      test_reset_flight();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
